// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time from instruction
// memory, holds it for decode and applies the Jump/Branch decision on accept.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [5:0]  opcode,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        req_q;
    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [5:0]  opcode_q;

    // The jump target keeps the upper nibble of the sequential PC; branch offsets are
    // signed word counts relative to the sequential PC. All sums wrap modulo 2^32.
    function automatic logic [31:0] next_pc(
        input logic [31:0] cur_pc,
        input logic [25:0] target,
        input logic        jump,
        input logic        branch,
        input logic        eq
    );
        logic [31:0]        pc4;
        logic signed [31:0] br_off;
        pc4    = cur_pc + 32'd4;
        br_off = {{14{target[15]}}, target[15:0], 2'b00};
        if (jump) begin
            next_pc = {pc4[31:28], target, 2'b00};
        end else if (branch && eq) begin
            next_pc = pc4 + br_off;
        end else begin
            next_pc = pc4;
        end
    endfunction

    assign pc_d = next_pc(inst_pc_q, inst_q[25:0], Jump, Branch, zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= {RESET_PC[31:2], 2'b00};
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            opcode_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                // Read data is only trusted here; rvalid in any other state is dropped.
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst_q    <= imem_rdata;
                        inst_pc_q <= pc_q;
                        opcode_q  <= imem_rdata[31:26];
                        valid_q   <= 1'b1;
                        state_q   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        valid_q  <= 1'b0;
                        opcode_q <= '0;
                        pc_q     <= pc_d;
                        req_q    <= 1'b1;
                        state_q  <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The PC register doubles as the fetch address: it only changes on decode accept.
    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign opcode     = opcode_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory/decode driver feeds a PC
// reference model that queues expected fetch addresses and words for an independent monitor.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int TOTAL_ACCEPTS = 70;
    localparam int IDLE_LIMIT    = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  opcode;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        zero = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .opcode     (opcode),
        .Jump       (Jump),
        .Branch     (Branch),
        .zero       (zero)
    );

    typedef struct packed {
        logic [31:0] word;
        logic        j;
        logic        b;
        logic        z;
        logic [3:0]  rdy_dly;
        logic [3:0]  lat;
        logic [3:0]  acc_dly;
    } cfg_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_inst_t;

    cfg_t        dir_q[$];
    logic [31:0] exp_addr_q[$];
    exp_inst_t   exp_inst_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req"},     {31'd0, imem_req},   32'd0);
        check32({tag, "_addr"},    imem_addr,           RESET_PC);
        check32({tag, "_valid"},   {31'd0, inst_valid}, 32'd0);
        check32({tag, "_inst"},    inst,                32'd0);
        check32({tag, "_inst_pc"}, inst_pc,             32'd0);
        check32({tag, "_opcode"},  {26'd0, opcode},     32'd0);
    endtask

    // Reference next-PC rule written as plain arithmetic on 32-bit integers.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               input logic j, input logic b, input logic z);
        logic [31:0]        pc4;
        logic signed [31:0] off;
        pc4 = pc + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) + (w & 32'h03FF_FFFF) * 32'd4;
        if (b && z) begin
            off = $signed(w[15:0]);
            return pc4 + off * 4;
        end
        return pc4;
    endfunction

    function automatic cfg_t next_cfg(input int idx, input bit reset_done);
        cfg_t c;
        if (idx < dir_q.size()) return dir_q[idx];
        c.word    = $urandom;
        c.j       = ($urandom_range(0, 3) == 0);
        c.b       = 1'($urandom_range(0, 1));
        c.z       = 1'($urandom_range(0, 1));
        c.rdy_dly = 4'($urandom_range(0, 3));
        c.lat     = 4'($urandom_range(0, 3));
        c.acc_dly = 4'($urandom_range(0, 3));
        if (!reset_done && idx >= 30) c.lat = 4'd2;
        return c;
    endfunction

    // Driver: plays instruction memory and decode, and steps the reference model.
    initial begin
        cfg_t        cfg;
        logic [31:0] model_pc;
        bit          outstanding;
        bit          req_seen;
        bit          hold_seen;
        bit          did_reset;
        int          lat_cnt;
        int          rdy_wait;
        int          acc_wait;
        int          fetch_idx;
        int          accepts;
        int          idle;

        outstanding = 0; req_seen = 0; hold_seen = 0; did_reset = 0;
        lat_cnt = 0; rdy_wait = 0; acc_wait = 0; fetch_idx = 0; accepts = 0; idle = 0;
        cfg = '0;

        // pc trail: 0 -> 4 -> 8 -> 12 -> 28 -> 0x40 -> 0 -> 0 -> 0xFFFFFFFC -> 0
        dir_q.push_back('{32'h0000_0020, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0});
        dir_q.push_back('{32'h0000_0020, 1'b0, 1'b0, 1'b0, 4'd4, 4'd1, 4'd5});
        dir_q.push_back('{32'h1000_0003, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0});
        dir_q.push_back('{32'h1000_0003, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd1});
        dir_q.push_back('{32'h0800_0010, 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 4'd0});
        dir_q.push_back('{32'h1000_FFEF, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0});
        dir_q.push_back('{32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0});
        dir_q.push_back('{32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0});
        dir_q.push_back('{32'h0000_0020, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0});

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        check32("req_at_release", {31'd0, imem_req}, 32'd0);
        model_pc = RESET_PC;
        exp_addr_q.push_back(RESET_PC);
        @(posedge clk);
        #1;
        check32("first_req", {31'd0, imem_req}, 32'd1);
        check32("first_addr", imem_addr, RESET_PC);

        while (accepts < TOTAL_ACCEPTS && idle < IDLE_LIMIT) begin
            if (!did_reset && outstanding && lat_cnt > 0 && fetch_idx > 30) begin
                imem_ready = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
                rst = 1'b1;
                #1;
                check_reset_outputs("midfetch");
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_addr_q.delete();
                exp_inst_q.delete();
                model_pc = RESET_PC;
                exp_addr_q.push_back(RESET_PC);
                outstanding = 0; req_seen = 0; hold_seen = 0; did_reset = 1;
                @(posedge clk);
                #1;
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                @(posedge clk);
                #1;
                imem_rvalid = 1'b0;
                check32("stale_rvalid_ignored", {31'd0, inst_valid}, 32'd0);
                check32("restart_addr", imem_addr, RESET_PC);
                continue;
            end

            imem_ready  = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            inst_ready  = 1'b0;
            Jump        = 1'($urandom_range(0, 1));
            Branch      = 1'($urandom_range(0, 1));
            zero        = 1'($urandom_range(0, 1));

            if (outstanding) begin
                if (lat_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = cfg.word;
                    exp_inst_q.push_back('{cfg.word, model_pc});
                    outstanding = 0;
                end else begin
                    lat_cnt--;
                end
            end else if (imem_req) begin
                if (!req_seen) begin
                    req_seen = 1;
                    cfg = next_cfg(fetch_idx, did_reset);
                    fetch_idx++;
                    rdy_wait = int'(cfg.rdy_dly);
                end
                if (rdy_wait == 0) begin
                    imem_ready  = 1'b1;
                    outstanding = 1;
                    lat_cnt     = int'(cfg.lat);
                    req_seen    = 0;
                    idle        = 0;
                end else begin
                    rdy_wait--;
                end
            end else if (inst_valid && $urandom_range(0, 3) == 0) begin
                imem_rvalid = 1'b1;
            end

            if (inst_valid) begin
                if (!hold_seen) begin
                    hold_seen = 1;
                    acc_wait  = int'(cfg.acc_dly);
                end
                if (acc_wait == 0) begin
                    inst_ready = 1'b1;
                    Jump       = cfg.j;
                    Branch     = cfg.b;
                    zero       = cfg.z;
                    model_pc   = model_next(model_pc, cfg.word, cfg.j, cfg.b, cfg.z);
                    exp_addr_q.push_back(model_pc);
                    hold_seen  = 0;
                    accepts++;
                    idle       = 0;
                end else begin
                    acc_wait--;
                end
            end

            idle++;
            @(posedge clk);
            #1;
        end

        checks++;
        if (idle >= IDLE_LIMIT) begin
            errors++;
            $display("FAIL timeout: no handshake for %0d cycles after %0d accepts", idle, accepts);
        end
        check32("reset_exercised", {31'd0, did_reset}, 32'd1);
        imem_ready = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: pops expectations on each handshake and checks hold stability.
    initial begin
        logic        prev_hold;
        logic        prev_stall;
        logic [31:0] p_inst;
        logic [31:0] p_pc;
        logic [31:0] p_addr;
        logic [5:0]  p_op;
        logic [31:0] ea;
        exp_inst_t   e;
        logic [31:0] ew;

        prev_hold = 0; prev_stall = 0;
        p_inst = '0; p_pc = '0; p_addr = '0; p_op = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold  = 0;
                prev_stall = 0;
                continue;
            end
            if (!inst_valid) check32("opcode_idle", {26'd0, opcode}, 32'd0);
            check32("single_outstanding", {31'd0, imem_req & inst_valid}, 32'd0);
            if (imem_req) check32("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (prev_stall) begin
                check32("req_held", {31'd0, imem_req}, 32'd1);
                check32("addr_held", imem_addr, p_addr);
            end
            if (prev_hold) begin
                check32("valid_held", {31'd0, inst_valid}, 32'd1);
                check32("inst_held", inst, p_inst);
                check32("inst_pc_held", inst_pc, p_pc);
                check32("opcode_held", {26'd0, opcode}, {26'd0, p_op});
            end
            if (imem_req && imem_ready) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_addr: unexpected request to %h", imem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    checks--;
                    check32("fetch_addr", imem_addr, ea);
                end
            end
            if (inst_valid && inst_ready) begin
                checks++;
                if (exp_inst_q.size() == 0) begin
                    errors++;
                    $display("FAIL held_word: unexpected word %h at pc %h", inst, inst_pc);
                end else begin
                    e  = exp_inst_q.pop_front();
                    ew = e.word;
                    checks--;
                    check32("held_inst", inst, ew);
                    check32("held_pc", inst_pc, e.pc);
                    check32("held_opcode", {26'd0, opcode}, {26'd0, ew[31:26]});
                end
            end
            prev_stall = imem_req && !imem_ready;
            p_addr     = imem_addr;
            prev_hold  = inst_valid && !inst_ready;
            p_inst     = inst;
            p_pc       = inst_pc;
            p_op       = opcode;
        end
    end

endmodule
